// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : router_pkg                                                    |
// | Brief   : Shared widths and word type for the router ingress slice.     |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  localparam int ADDR_W     = 2;
  localparam int NUM_PORTS  = 4;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W_DEF-1:0] data;
  } route_word_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : sync_fifo                                                     |
// | Brief   : Generic single-clock FIFO with storage, pointers and count.   |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; a reset only needs to empty the queue logically.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_ingress_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : router_ingress_fifo                                           |
// | Brief   : Ingress FIFO feeding the 4-way router with dispatch counters. |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module router_ingress_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [ADDR_W-1:0]              in_addr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           halt,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_en,
  output logic [ADDR_W-1:0]              dout_addr,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] sent_cnt
);

  localparam int c_word_w = DATA_WIDTH + ADDR_W;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic                  w_push;
  logic                  w_pop;
  logic [c_word_w-1:0]   w_wdata;
  logic [c_word_w-1:0]   w_head;
  logic [ADDR_W-1:0]     w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_en;
  logic [ADDR_W-1:0]     r_dout_addr;

  // Ready depends only on registered occupancy, never on in_valid or this cycle's pop.
  assign in_ready    = resetn && !full;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = !empty && !halt;
  assign w_wdata     = {in_addr, in_data};
  assign w_head_addr = w_head[c_word_w-1 -: ADDR_W];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (c_word_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (w_wdata),
    .rdata  (w_head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout      <= '0;
      r_dout_en   <= 1'b0;
      r_dout_addr <= '0;
    end else begin
      r_dout_en <= w_pop;
      if (w_pop) begin
        r_dout      <= w_head_data;
        r_dout_addr <= w_head_addr;
      end
    end
  end

  assign dout      = r_dout;
  assign dout_en   = r_dout_en;
  assign dout_addr = r_dout_addr;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [CNT_WIDTH-1:0] r_cnt;

    // Saturating so a long run cannot make a busy port look idle.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
      end else if (w_pop && (w_head_addr == ADDR_W'(gi)) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end

    assign sent_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_router_ingress_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : tb_router_ingress_fifo                                        |
// | Brief   : Scoreboard bench for router_ingress_fifo.                     |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_router_ingress_fifo;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [DW-1:0]     in_data;
  logic [1:0]        in_addr;
  logic              in_valid;
  logic              in_ready;
  logic              halt;
  logic [DW-1:0]     dout;
  logic              dout_en;
  logic [1:0]        dout_addr;
  logic [2:0]        count;
  logic              full;
  logic              empty;
  logic [4*CW-1:0]   sent_cnt;

  int          checks = 0;
  int          errors = 0;
  int          in_total = 0;
  int          out_total = 0;
  route_word_t exp_q[$];

  router_ingress_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .halt      (halt),
    .dout      (dout),
    .dout_en   (dout_en),
    .dout_addr (dout_addr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sent(int i);
    return sent_cnt[i*CW +: CW];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every dispatched word must match the oldest accepted word.
  always @(negedge clk) begin
    route_word_t e;
    if (dout_en === 1'b1) begin
      out_total++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got dout=%0h addr=%0d expected no output", dout, dout_addr);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.data || dout_addr !== e.addr) begin
          errors++;
          $display("FAIL out_word: got %0h@%0d expected %0h@%0d", dout, dout_addr, e.data, e.addr);
        end
      end
    end
  end

  // Called between edges; in_ready is stable there and independent of in_valid.
  task automatic push_word(logic [DW-1:0] d, logic [1:0] a);
    route_word_t w;
    in_data  = d;
    in_addr  = a;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready === 1'b1) begin
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
        in_total++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL push_timeout: got in_ready=0 expected 1 within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_0001;
    in_addr  = 2'd3;
    halt     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_dout_en", dout_en, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_addr", dout_addr, 0);
      check("rst_sent_cnt", sent_cnt, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    exp_q.delete();
    in_total  = 0;
    out_total = 0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    halt     = 1'b0;

    // Reset and single word with one-cycle latency
    do_reset();
    push_word(32'h0000BEAD, 2'd2);
    check("single_en_n", dout_en, 0);
    check("single_count", count, 1);
    @(posedge clk); #1;
    check("single_en_n1", dout_en, 1);
    check("single_dout", dout, 32'h0000BEAD);
    check("single_addr", dout_addr, 2);
    @(posedge clk); #1;
    check("single_en_off", dout_en, 0);
    check("single_hold", dout, 32'h0000BEAD);
    check("single_sent2", sent(2), 1);
    check("single_empty", empty, 1);

    // Fill while halted, reject a fifth word, then drain in order
    do_reset();
    halt = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'(i + 1), 2'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h5;
    in_addr  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("fill_reject_count", count, 4);
    check("fill_halt_en", dout_en, 0);
    in_valid = 1'b0;
    halt     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("fill_drain_en", dout_en, 1);
      check("fill_drain_addr", dout_addr, 32'(k));
    end
    @(posedge clk); #1;
    check("fill_drain_done", dout_en, 0);
    check("fill_empty", empty, 1);
    for (int p = 0; p < 4; p++) check("fill_sent", sent(p), 1);

    // Streaming: one word per cycle, occupancy never above one
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_word(32'hA000 + DW'(i), 2'(i % 4));
      check("stream_count", count, 1);
      check("stream_en", dout_en, (i == 0) ? 0 : 1);
    end
    @(posedge clk); #1;
    check("stream_last_en", dout_en, 1);
    @(posedge clk); #1;
    check("stream_done_en", dout_en, 0);
    check("stream_sent0", sent(0), 5);
    check("stream_sent3", sent(3), 5);

    // Full with simultaneous pop: ready rises one cycle after the first pop
    do_reset();
    halt = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h11 + DW'(i), 2'(3 - i));
    halt     = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA;
    in_addr  = 2'd1;
    check("fp_ready_full", in_ready, 0);
    @(posedge clk); #1;
    check("fp_ready_rise", in_ready, 1);
    check("fp_count", count, 3);
    check("fp_first_pop", dout_en, 1);
    begin
      route_word_t w;
      w.addr = 2'd1;
      w.data = 32'hA;
      exp_q.push_back(w);
      in_total++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_word(32'hB, 2'd2);
    push_word(32'hC, 2'd3);
    push_word(32'hD, 2'd0);
    repeat (10) @(posedge clk);
    #1;
    check("fp_total", out_total, in_total);
    check("fp_total_n", out_total, 8);
    check("fp_queue_left", exp_q.size(), 0);
    check("fp_empty", empty, 1);

    // Reset mid-operation flushes queued words
    do_reset();
    push_word(32'h77, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_pre_dout", dout, 32'h77);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'hC0 + DW'(i), 2'd1);
    check("mid_pre_count", count, 3);
    resetn = 1'b0;
    #1;
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_ready", in_ready, 0);
    check("mid_dout", dout, 0);
    check("mid_dout_en", dout_en, 0);
    check("mid_sent", sent_cnt, 0);
    exp_q.delete();
    halt = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("mid_no_stale", dout_en, 0);
      check("mid_stay_empty", empty, 1);
    end

    // Saturation of a dispatch counter
    do_reset();
    for (int i = 0; i < 300; i++) push_word(DW'(i), 2'd1);
    repeat (4) @(posedge clk);
    #1;
    check("sat_sent1", sent(1), 255);
    check("sat_sent0", sent(0), 0);
    check("sat_sent2", sent(2), 0);
    check("sat_sent3", sent(3), 0);
    check("sat_total", out_total, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
